// File: rtl/encoder_4to2.sv
// Registered priority encoder: maps a request vector to the index of its winning set bit,
// qualified by valid (any bit set) and multi (two or more bits set). One cycle of latency.
module encoder_4to2 #(
    parameter int unsigned N         = 4,
    parameter int unsigned OUT_W     = 2,
    parameter bit          HIGH_PRIO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     i,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic             multi
);

    logic [OUT_W-1:0] idx;
    logic             any;
    logic             many;

    // Scan in ascending order so the last hit wins for HIGH_PRIO, descending otherwise.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        many = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            int unsigned pos;
            pos = HIGH_PRIO ? k : (N - 1 - k);
            if (i[pos]) begin
                if (any) begin
                    many = 1'b1;
                end
                any = 1'b1;
                idx = OUT_W'(pos);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            out   <= idx;
            valid <= any;
            multi <= many;
        end
    end

endmodule

// File: tb/tb_encoder_4to2.sv
// Self-checking bench for encoder_4to2: one instance per priority mode, driven from shared
// stimulus and compared against hand-computed tables and an independent reference model.
module tb_encoder_4to2;

    logic       clk;
    logic       rst_n;
    logic [3:0] i;
    logic [1:0] out_hi, out_lo;
    logic       valid_hi, valid_lo, multi_hi, multi_lo;

    int checks = 0;
    int errors = 0;

    encoder_4to2 #(.N(4), .OUT_W(2), .HIGH_PRIO(1'b1)) u_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i),
        .out   (out_hi),
        .valid (valid_hi),
        .multi (multi_hi)
    );

    encoder_4to2 #(.N(4), .OUT_W(2), .HIGH_PRIO(1'b0)) u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i),
        .out   (out_lo),
        .valid (valid_lo),
        .multi (multi_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vec;
        logic [1:0] hi;
        logic [1:0] lo;
        logic       v;
        logic       m;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t, i=%b)", name, act, exp, $time, i);
        end
    endtask

    task automatic check_all(input logic [1:0] ehi, input logic [1:0] elo, input logic ev,
                             input logic em);
        check("out_hi", {2'b00, out_hi}, {2'b00, ehi});
        check("valid_hi", {3'b000, valid_hi}, {3'b000, ev});
        check("multi_hi", {3'b000, multi_hi}, {3'b000, em});
        check("out_lo", {2'b00, out_lo}, {2'b00, elo});
        check("valid_lo", {3'b000, valid_lo}, {3'b000, ev});
        check("multi_lo", {3'b000, multi_lo}, {3'b000, em});
    endtask

    // Independent reference: explicit priority chains plus $countones.
    task automatic check_model(input logic [3:0] v);
        logic [1:0] ehi, elo;
        ehi = v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
        elo = v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
        check_all(ehi, elo, v != 4'b0000, $countones(v) >= 2);
    endtask

    // Drive between edges, then sample just after the capturing edge.
    task automatic step(input logic [3:0] v);
        @(negedge clk);
        i = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{4'b0001, 2'd0, 2'd0, 1'b1, 1'b0};
        tbl[1] = '{4'b0010, 2'd1, 2'd1, 1'b1, 1'b0};
        tbl[2] = '{4'b0100, 2'd2, 2'd2, 1'b1, 1'b0};
        tbl[3] = '{4'b1000, 2'd3, 2'd3, 1'b1, 1'b0};
        tbl[4] = '{4'b0000, 2'd0, 2'd0, 1'b0, 1'b0};
        tbl[5] = '{4'b1010, 2'd3, 2'd1, 1'b1, 1'b1};
        tbl[6] = '{4'b0110, 2'd2, 2'd1, 1'b1, 1'b1};
        tbl[7] = '{4'b1111, 2'd3, 2'd0, 1'b1, 1'b1};
        tbl[8] = '{4'b0011, 2'd1, 2'd0, 1'b1, 1'b1};
        tbl[9] = '{4'b1100, 2'd3, 2'd2, 1'b1, 1'b1};

        // Reset held with all requests active; outputs must be clear before any edge.
        rst_n = 1'b0;
        i     = 4'b1111;
        #1;
        check_all(2'd0, 2'd0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all(2'd0, 2'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 10; n++) begin
            step(tbl[n].vec);
            check_all(tbl[n].hi, tbl[n].lo, tbl[n].v, tbl[n].m);
        end

        // Input changes between edges must not reach the outputs.
        step(4'b0101);
        check_all(2'd2, 2'd0, 1'b1, 1'b1);
        #1 i = 4'b1000;
        #2;
        check_all(2'd2, 2'd0, 1'b1, 1'b1);

        // Full sweep with wrap to zero and a half-period reset pulse partway through.
        for (int v = 0; v <= 16; v++) begin
            if (v == 9) begin
                #1 rst_n = 1'b0;
                #1;
                check_all(2'd0, 2'd0, 1'b0, 1'b0);
                #4;
                rst_n = 1'b1;
                i     = 4'd9;
                @(posedge clk);
                #1;
                check_model(4'd9);
            end else begin
                step(4'(v));
                check_model(4'(v));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_4to2.md
# encoder_4to2

Registered 4-to-2 priority encoder that converts a 4-bit request vector into the binary index of its active bit. A valid flag and a multi-hot flag qualify the index. It sits between a one-hot or request-style source and downstream logic that needs a compact index, and provides one cycle of registered latency.

## Interface
- `N`, default 4: input vector width; must be a power of two ≥ 2.
- `OUT_W`, default 2: index width; must equal log2(N).
- `HIGH_PRIO`, default 1: 1 means the highest set bit wins; 0 means the lowest set bit wins.
- One clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `i` input N: request vector, sampled every rising edge.
- `out` output OUT_W: registered binary index of the winning set bit of `i`.
- `valid` output 1: registered; 1 when at least one bit of `i` was set.
- `multi` output 1: registered; 1 when two or more bits of `i` were set.

## Operation
- Combinational stage:
  - With `HIGH_PRIO`=1, `idx` is the largest k with i[k]=1.
  - With `HIGH_PRIO`=0, `idx` is the smallest k with i[k]=1.
  - `any` = OR-reduce(i).
  - `many` = 1 when popcount(i) ≥ 2.
- Zero input (i = 0):
  - `idx` is forced to 0 and `any` = 0.
  - `out` reads 00 with `valid`=0; consumers must qualify `out` with `valid`.
- One-hot input:
  - `out` is the bit position; 0001→00, 0010→01, 0100→10, 1000→11.
  - `valid`=1, `multi`=0.
- Multi-hot input:
  - `out` is the priority winner per `HIGH_PRIO`.
  - `valid`=1, `multi`=1.
- Output register:
  - On each rising edge, `out`←`idx`, `valid`←`any`, `multi`←`many`.
  - There is no enable and no hold; a new value is captured every cycle.
- X or Z on `i` are not defined inputs; the bench drives known values only.
- No internal state exists beyond the output registers. No FSM.

## Timing
- Latency is exactly 1 clock. The value of `i` present at rising edge n appears on the outputs after edge n and holds until edge n+1.
- Throughput is one new vector per clock.
- Reset:
  - While `rst_n`=0, the outputs are forced to `out`=0, `valid`=0, `multi`=0 immediately, independent of `clk`.
  - Reset asserted mid-stream clears the outputs asynchronously; the pipeline value in flight is discarded.
  - The first rising edge with `rst_n`=1 captures the current `i` normally.
  - Deassertion must meet recovery timing to `clk`; no internal synchroniser is included.
- `i` must be stable for setup/hold around the rising edge. Changes of `i` between edges have no effect on the outputs.
- The outputs are glitch-free registers; there is no combinational path from `i` to any output.

## Test plan
- Reset:
  - Hold `rst_n`=0 for 3 cycles with i=1111.
  - Required: out=00, valid=0, multi=0 throughout, including before the first clock edge.
- One-hot walk:
  - Drive i=0001, 0010, 0100, 1000 on consecutive cycles.
  - Required: one cycle later, out=00, 01, 10, 11 with valid=1 and multi=0 each cycle.
- Zero input:
  - Drive i=0000.
  - Required: next cycle out=00, valid=0, multi=0.
- Priority (`HIGH_PRIO`=1):
  - i=1010 → out=11, multi=1.
  - i=0110 → out=10, multi=1.
  - i=1111 → out=11, valid=1, multi=1.
  - Repeat with `HIGH_PRIO`=0: 1010 → 01, 0110 → 01, 1111 → 00.
- Full sweep:
  - Increment i from 0000 to 1111, one value per clock, 16 cycles, wrapping back to 0000.
  - Required: each cycle's outputs match a reference model of the previous cycle's `i`, including the wrap from 1111 to 0000 (out=00, valid=0).
- Mid-stream reset:
  - During the sweep, pulse `rst_n` low for half a clock period between edges.
  - Required: outputs clear immediately.
  - Required: the first edge after release shows the encoding of the `i` value sampled at that edge.
